// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs instruction fields into 16-bit words and writes them to instruction RAM
// Optional feature macro: IMM_RANGE_CHECK_EN (reject IMM values outside -128..127).
module instruction_encoder #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_kind,
   input  logic [3:0]        in_op,
   input  logic [3:0]        in_ext,
   input  logic [3:0]        in_rdest,
   input  logic [3:0]        in_rsrc,
   input  logic [15:0]       in_imm,
   input  logic              load_base,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              err,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam logic [1:0] KIND_RTYPE = 2'b00;
   localparam logic [1:0] KIND_IMM   = 2'b01;
   localparam logic [1:0] KIND_MEM   = 2'b10;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_MEM   = 4'b0100;
   localparam logic [3:0] EXT_LOAD = 4'b0000;
   localparam logic [3:0] EXT_STOR = 4'b0100;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CHECK = 2'b01,
      WRITE = 2'b10,
      ERR   = 2'b11
   } state_t;

   state_t state, state_next;

   logic [1:0]  kind_q;
   logic [3:0]  op_q;
   logic [3:0]  ext_q;
   logic [3:0]  rdest_q;
   logic [3:0]  rsrc_q;
`ifdef IMM_RANGE_CHECK_EN
   logic [15:0] imm_q;
`else
   logic [7:0]  imm_q;
   logic        unused_imm_hi;
`endif

   logic            transfer;
   logic            imm_ok;
   logic            legal;
   logic [15:0]     word;
   logic [ADDR_W:0] count_inc;

   function automatic logic imm_op_legal(input logic [3:0] op);
      case (op)
         4'b0001, 4'b0010, 4'b0011, 4'b0101,
         4'b0110, 4'b1001, 4'b1011, 4'b1110: imm_op_legal = 1'b1;
         default:                            imm_op_legal = 1'b0;
      endcase
   endfunction

   // load_base takes priority over a bundle, so it blocks the handshake outright.
   assign in_ready  = (state == IDLE) && !full && !load_base;
   assign transfer  = in_valid && in_ready;
   assign mem_we    = (state == WRITE);
   assign err       = (state == ERR);
   assign count_inc = count + (ADDR_W+1)'(1);

`ifdef IMM_RANGE_CHECK_EN
   assign imm_ok = (imm_q[15:8] == {8{imm_q[7]}});
`else
   assign imm_ok        = 1'b1;
   assign unused_imm_hi = ^in_imm[15:8];
`endif

   always_comb begin
      word  = 16'h0000;
      legal = 1'b0;
      case (kind_q)
         KIND_RTYPE: begin
            word  = {OP_RTYPE, rdest_q, ext_q, rsrc_q};
            legal = 1'b1;
         end
         KIND_IMM: begin
            word  = {op_q, rdest_q, imm_q[7:0]};
            legal = imm_op_legal(op_q) && imm_ok;
         end
         KIND_MEM: begin
            word  = {OP_MEM, rdest_q, ext_q, rsrc_q};
            legal = (ext_q == EXT_LOAD) || (ext_q == EXT_STOR);
         end
         default: begin
            word  = 16'h0000;
            legal = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (transfer) state_next = CHECK;
         CHECK:   state_next = legal ? WRITE : ERR;
         WRITE:   state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kind_q  <= 2'b00;
         op_q    <= 4'h0;
         ext_q   <= 4'h0;
         rdest_q <= 4'h0;
         rsrc_q  <= 4'h0;
         imm_q   <= '0;
      end else if (transfer) begin
         kind_q  <= in_kind;
         op_q    <= in_op;
         ext_q   <= in_ext;
         rdest_q <= in_rdest;
         rsrc_q  <= in_rsrc;
`ifdef IMM_RANGE_CHECK_EN
         imm_q   <= in_imm;
`else
         imm_q   <= in_imm[7:0];
`endif
      end
   end

   // Address, count and full only move on load_base (IDLE) or a completed write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= 16'h0000;
         count     <= '0;
         full      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_base) begin
                  mem_addr <= base_addr;
                  count    <= '0;
                  full     <= 1'b0;
               end
            end
            CHECK: begin
               if (legal) mem_wdata <= word;
            end
            WRITE: begin
               mem_addr <= mem_addr + ADDR_W'(1);
               count    <= count_inc;
               full     <= (count_inc == DEPTH_C);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder (DEPTH=4 build)
module tb_instruction_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic [3:0]  in_op;
   logic [3:0]  in_ext;
   logic [3:0]  in_rdest;
   logic [3:0]  in_rsrc;
   logic [15:0] in_imm;
   logic        load_base;
   logic [7:0]  base_addr;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        err;
   logic        full;
   logic [8:0]  count;

   int tests  = 0;
   int failed = 0;

   instruction_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kind   (in_kind),
      .in_op     (in_op),
      .in_ext    (in_ext),
      .in_rdest  (in_rdest),
      .in_rsrc   (in_rsrc),
      .in_imm    (in_imm),
      .load_base (load_base),
      .base_addr (base_addr),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .err       (err),
      .full      (full),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drive(input logic [1:0] kind, input logic [3:0] op, input logic [3:0] ext,
                        input logic [3:0] rdest, input logic [3:0] rsrc, input logic [15:0] imm);
      in_kind  = kind;
      in_op    = op;
      in_ext   = ext;
      in_rdest = rdest;
      in_rsrc  = rsrc;
      in_imm   = imm;
      in_valid = 1'b1;
   endtask

   // Sends one bundle and checks the CHECK cycle and the WRITE/ERR cycle; returns at the negedge inside WRITE/ERR.
   task automatic xfer(input logic [1:0] kind, input logic [3:0] op, input logic [3:0] ext,
                       input logic [3:0] rdest, input logic [3:0] rsrc, input logic [15:0] imm,
                       input logic legal, input logic [15:0] wexp, input logic [7:0] aexp,
                       input string tag);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      drive(kind, op, ext, rdest, rsrc, imm);
      for (int i = 0; i < 10; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_accept"}, 32'(ok), 32'd1);
      if (!ok) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_check_we"}, 32'(mem_we), 32'd0);
      @(negedge clk);
      if (legal) begin
         chk({tag, "_we"},    32'(mem_we),    32'd1);
         chk({tag, "_addr"},  32'(mem_addr),  32'(aexp));
         chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wexp));
         chk({tag, "_err"},   32'(err),       32'd0);
      end else begin
         chk({tag, "_err"},   32'(err),       32'd1);
         chk({tag, "_we"},    32'(mem_we),    32'd0);
         chk({tag, "_addr"},  32'(mem_addr),  32'(aexp));
      end
   endtask

   task automatic pulse_load(input logic [7:0] base);
      @(negedge clk);
      base_addr = base;
      load_base = 1'b1;
      @(posedge clk);
      #1 load_base = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_kind   = 2'b00;
      in_op     = 4'h0;
      in_ext    = 4'h0;
      in_rdest  = 4'h0;
      in_rsrc   = 4'h0;
      in_imm    = 16'h0000;
      load_base = 1'b0;
      base_addr = 8'h00;
      repeat (3) @(negedge clk);

      chk("rst_in_ready", 32'(in_ready),  32'd1);
      chk("rst_mem_we",   32'(mem_we),    32'd0);
      chk("rst_mem_addr", 32'(mem_addr),  32'd0);
      chk("rst_wdata",    32'(mem_wdata), 32'd0);
      chk("rst_err",      32'(err),       32'd0);
      chk("rst_full",     32'(full),      32'd0);
      chk("rst_count",    32'(count),     32'd0);
      reset = 1'b0;

      // load_base with a bundle present: load wins, no transfer
      @(negedge clk);
      base_addr = 8'h10;
      load_base = 1'b1;
      drive(2'b00, 4'h0, 4'h5, 4'h3, 4'h5, 16'h0000);
      #1 chk("load_blocks_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 begin
         load_base = 1'b0;
         in_valid  = 1'b0;
      end
      @(negedge clk);
      chk("load_addr",  32'(mem_addr), 32'h10);
      chk("load_count", 32'(count),    32'd0);
      @(negedge clk);
      chk("load_no_xfer_we", 32'(mem_we), 32'd0);

      xfer(2'b00, 4'h0, 4'h5, 4'h3, 4'h5, 16'h0000, 1'b1, 16'h0355, 8'h10, "rtype");
      @(negedge clk);
      chk("rtype_count", 32'(count), 32'd1);

      xfer(2'b01, 4'h5, 4'h0, 4'h2, 4'h0, 16'h007F, 1'b1, 16'h527F, 8'h11, "imm");
      xfer(2'b10, 4'h0, 4'h0, 4'h1, 4'h4, 16'h0000, 1'b1, 16'h4104, 8'h12, "load");
      xfer(2'b10, 4'h0, 4'h4, 4'h6, 4'h7, 16'h0000, 1'b1, 16'h4647, 8'h13, "stor");

      @(negedge clk);
      chk("full_flag",  32'(full),     32'd1);
      chk("full_count", 32'(count),    32'd4);
      chk("full_ready", 32'(in_ready), 32'd0);

      // fifth bundle stalls while full, then lands at the new base
      drive(2'b00, 4'h0, 4'h1, 4'hA, 4'hB, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk("stall_we",    32'(mem_we),   32'd0);
      end
      base_addr = 8'h40;
      load_base = 1'b1;
      @(posedge clk);
      #1 load_base = 1'b0;
      @(negedge clk);
      chk("reload_ready", 32'(in_ready), 32'd1);
      chk("reload_full",  32'(full),     32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("held_check_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      chk("held_we",    32'(mem_we),    32'd1);
      chk("held_addr",  32'(mem_addr),  32'h40);
      chk("held_wdata", 32'(mem_wdata), 32'h0A1B);

      xfer(2'b01, 4'h7, 4'h0, 4'h1, 4'h0, 16'h0001, 1'b0, 16'h0000, 8'h41, "bad_op");
      xfer(2'b10, 4'h0, 4'h2, 4'h1, 4'h2, 16'h0000, 1'b0, 16'h0000, 8'h41, "bad_ext");
      xfer(2'b11, 4'h0, 4'h0, 4'h1, 4'h2, 16'h0000, 1'b0, 16'h0000, 8'h41, "bad_kind");
      @(negedge clk);
      chk("err_addr_hold",  32'(mem_addr), 32'h41);
      chk("err_count_hold", 32'(count),    32'd1);

`ifdef IMM_RANGE_CHECK_EN
      xfer(2'b01, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0080, 1'b0, 16'h0000, 8'h41, "imm_range_pos");
      xfer(2'b01, 4'h1, 4'h0, 4'h0, 4'h0, 16'hFF80, 1'b1, 16'h1080, 8'h41, "imm_range_neg");
`else
      xfer(2'b01, 4'h1, 4'h0, 4'h0, 4'h0, 16'h0080, 1'b1, 16'h1080, 8'h41, "imm_trunc");
`endif
      @(negedge clk);
      chk("imm_count", 32'(count), 32'd2);

      // reset asserted inside the WRITE cycle
      xfer(2'b00, 4'h0, 4'h5, 4'h3, 4'h5, 16'h0000, 1'b1, 16'h0355, 8'h42, "pre_reset");
      reset = 1'b1;
      #1;
      chk("midrst_we",    32'(mem_we),    32'd0);
      chk("midrst_addr",  32'(mem_addr),  32'd0);
      chk("midrst_wdata", 32'(mem_wdata), 32'd0);
      chk("midrst_count", 32'(count),     32'd0);
      chk("midrst_ready", 32'(in_ready),  32'd1);
      chk("midrst_full",  32'(full),      32'd0);
      chk("midrst_err",   32'(err),       32'd0);
      @(negedge clk);
      reset = 1'b0;
      pulse_load(8'h00);
      xfer(2'b00, 4'h0, 4'h5, 4'h3, 4'h5, 16'h0000, 1'b1, 16'h0355, 8'h00, "post_reset");
      @(negedge clk);
      chk("post_count", 32'(count),    32'd1);
      chk("post_addr",  32'(mem_addr), 32'h01);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the CPU controller's decoder: accepts instruction fields (class, opcode, extension, registers, immediate) over a valid/ready handshake.
- Packs the fields into the 16-bit instruction format that the controller decodes, checks that the encoding is legal, and writes the word into instruction memory at an auto-incrementing address.
- Used by the program loader and by the self-test benches to build programs in instruction RAM.

Parameters:
- ADDR_W, 8, width of the instruction-memory address.
- DEPTH, 256, maximum number of words per program (must be ≤ 2^ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  field bundle present.
- in_ready  output  1  encoder can accept a bundle this cycle.
- in_kind  input  2  00 RTYPE, 01 IMM, 10 MEM, 11 illegal.
- in_op  input  4  opcode, bits [15:12]; used for IMM only.
- in_ext  input  4  op-extension, bits [7:4]; used for RTYPE and MEM.
- in_rdest  input  4  destination/data register, bits [11:8].
- in_rsrc  input  4  source/address register, bits [3:0].
- in_imm  input  16  immediate value (IMM only).
- load_base  input  1  load base_addr and clear the word count.
- base_addr  input  ADDR_W  start address of the program.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  encoded instruction word.
- err  output  1  one-cycle pulse: bundle rejected.
- full  output  1  DEPTH words written since the last load_base.
- count  output  ADDR_W+1  number of words written since the last load_base.

Behaviour:
- Reset: state IDLE; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; err=0; full=0; count=0. Reset mid-operation aborts any pending word with no write.
- Encoding rules:
  - RTYPE: {0000, rdest, ext, rsrc}. Any ext value is legal.
  - IMM: {op, rdest, imm[7:0]}. op is legal only if it is one of 0001, 0010, 0011, 0101, 0110, 1001, 1011, 1110.
  - MEM: {0100, rdest, ext, rsrc}. ext is legal only if it is 0000 (LOAD) or 0100 (STOR).
  - kind 11 is always illegal.
- State IDLE:
  - in_ready = !full.
  - A transfer occurs when in_valid && in_ready. On a transfer, latch the fields and go to CHECK.
  - load_base is honoured only in IDLE: mem_addr ← base_addr, count ← 0, full ← 0.
  - If load_base and in_valid are both high in the same cycle, load_base wins and no transfer occurs (in_ready is forced to 0 that cycle).
- State CHECK (1 cycle, in_ready=0):
  - Build the word into mem_wdata and evaluate legality.
  - Legal → WRITE. Illegal → ERR.
- State WRITE (1 cycle):
  - mem_we=1 with mem_addr and mem_wdata stable.
  - Next edge: mem_addr ← mem_addr+1 (wraps modulo 2^ADDR_W), count ← count+1.
  - full ← (count+1 == DEPTH).
  - Go to IDLE.
- State ERR (1 cycle):
  - err=1; mem_we=0; mem_addr and count unchanged; go to IDLE.
- Latency: transfer accepted at edge N; mem_we is high during cycle N+2.
  - Sustained throughput is 1 word per 3 cycles.
- load_base and in_valid are ignored in CHECK, WRITE and ERR.
- While full, bundles stall (in_ready=0) and are not dropped.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: an IMM bundle is also illegal when in_imm[15:8] is not all copies of in_imm[7], i.e. the value is outside the signed range -128..127. Such a bundle takes the ERR path with no write.
- Undefined: in_imm[15:8] is ignored and the immediate is silently truncated to 8 bits.

Test Plan:
- load_base with base_addr=0x10, then RTYPE rdest=3, ext=0101, rsrc=5 → mem_we at cycle N+2, mem_addr=0x10, mem_wdata=0x0355, count=1.
- IMM op=0101, rdest=2, imm=0x007F, followed by MEM LOAD rdest=1, rsrc=4 and MEM STOR rdest=6, rsrc=7 → words 0x527F, 0x4104, 0x4647 at consecutive addresses; err stays 0.
- IMM op=0111 (illegal), then MEM ext=0010 (illegal), then kind=11 → three err pulses, mem_we never asserted, mem_addr and count unchanged.
- DEPTH=4 build: write 4 legal words → full=1, in_ready=0; a 5th bundle held valid is not accepted until load_base, after which it is written at the new base address.
- Assert reset during WRITE → mem_we drops immediately, all outputs return to reset values; pulse load_base with base_addr=0x00 and write 0x0355 → lands at address 0x00.
- IMM_RANGE_CHECK_EN defined: imm=0x0080 → err pulse, no write; imm=0xFF80 → word {op, rdest, 0x80} written. Macro undefined: imm=0x0080 → word written with low byte 0x80.
